// File: rtl/scan_pipe_reg_if.sv
// Handshake/bus bundle for scan_pipe_reg: functional data path plus scan controls.
// Chain length (and so SCNT width) grows when SCAN_PIPE_PARITY_EN is defined.
interface scan_pipe_reg_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
);
`ifdef SCAN_PIPE_PARITY_EN
    localparam int L = DEPTH * (WIDTH + 2);
`else
    localparam int L = DEPTH * (WIDTH + 1);
`endif
    localparam int CNTW = $clog2(L + 1);

    logic             SE;
    logic             SI;
    logic             SO;
    logic             EN;
    logic [WIDTH-1:0] D;
    logic             DV;
    logic [WIDTH-1:0] Q;
    logic             QV;
    logic [CNTW-1:0]  SCNT;
    logic             SDONE;
    logic             PERR;

    modport master (output SE, SI, EN, D, DV, input SO, Q, QV, SCNT, SDONE, PERR);
    modport slave  (input SE, SI, EN, D, DV, output SO, Q, QV, SCNT, SDONE, PERR);
endinterface

// File: rtl/scan_pipe_reg.sv
// Scan-testable DEPTH x WIDTH pipeline register with per-stage valid and a chain shift counter.
// Optional per-stage parity with sticky PERR is enabled by defining SCAN_PIPE_PARITY_EN.
module scan_pipe_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic           CP,
    input  logic           CD,
    scan_pipe_reg_if.slave bus
);
`ifdef SCAN_PIPE_PARITY_EN
    localparam int E = WIDTH + 2;
`else
    localparam int E = WIDTH + 1;
`endif
    localparam int L    = DEPTH * E;
    localparam int CNTW = $clog2(L + 1);

    // Whole bank kept as one vector in chain order: stage s occupies [s*E +: E],
    // laid out {[parity], valid, data}, so a scan shift is a 1-bit left shift
    // and a functional advance is an E-bit left shift.
    logic [L-1:0]    chain;
    logic [L-1:0]    func_next;
    logic [E-1:0]    stage_in;
    logic [CNTW-1:0] scnt;
    logic            sdone;

    always_comb begin
        stage_in = '0;
`ifdef SCAN_PIPE_PARITY_EN
        stage_in = {^bus.D, bus.DV, bus.D};
`else
        stage_in = {bus.DV, bus.D};
`endif
    end

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign func_next[E-1:0] = stage_in;
        end else begin : g_body
            assign func_next[s*E +: E] = chain[(s-1)*E +: E];
        end
    end

    always_ff @(posedge CP or posedge CD) begin
        if (CD)          chain <= '0;
        else if (bus.SE) chain <= {chain[L-2:0], bus.SI};
        else if (bus.EN) chain <= func_next;
    end

    // SDONE fires only on the L-1 -> L transition; saturation keeps it from re-firing.
    always_ff @(posedge CP or posedge CD) begin
        if (CD) begin
            scnt  <= '0;
            sdone <= 1'b0;
        end else if (!bus.SE) begin
            scnt  <= '0;
            sdone <= 1'b0;
        end else begin
            sdone <= (scnt == CNTW'(L - 1));
            if (scnt != CNTW'(L)) scnt <= scnt + 1'b1;
        end
    end

`ifdef SCAN_PIPE_PARITY_EN
    logic perr;

    always_ff @(posedge CP or posedge CD) begin
        if (CD)
            perr <= 1'b0;
        else if (!bus.SE && bus.QV && ((^bus.Q) != chain[L-1]))
            perr <= 1'b1;
    end

    assign bus.PERR = perr;
`else
    assign bus.PERR = 1'b0;
`endif

    assign bus.Q     = chain[(DEPTH-1)*E +: WIDTH];
    assign bus.QV    = chain[(DEPTH-1)*E + WIDTH];
    assign bus.SO    = chain[L-1];
    assign bus.SCNT  = scnt;
    assign bus.SDONE = sdone;
endmodule

// File: tb/tb_scan_pipe_reg.sv
// Directed + randomized bench for scan_pipe_reg against a stage-level reference model.
module tb_scan_pipe_reg;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
`ifdef SCAN_PIPE_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int E = WIDTH + 1 + PAR;
    localparam int L = DEPTH * E;

    logic CP = 1'b0;
    logic CD = 1'b1;
    int   tests = 0;
    int   fails = 0;

    scan_pipe_reg_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    scan_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.CP(CP), .CD(CD), .bus(bus));

    always #5 CP = ~CP;

    // Reference model: one record per stage, chain only materialised for scan moves.
    logic [WIDTH-1:0] m_d [DEPTH];
    bit               m_v [DEPTH];
    bit               m_p [DEPTH];
    int               m_scnt;
    bit               m_sdone;
    bit               m_perr;
    bit               mb  [L];
    bit               tgt [L];

    function automatic void m_reset();
        for (int s = 0; s < DEPTH; s++) begin
            m_d[s] = '0; m_v[s] = 0; m_p[s] = 0;
        end
        m_scnt = 0; m_sdone = 0; m_perr = 0;
    endfunction

    function automatic void pack_m();
        for (int s = 0; s < DEPTH; s++) begin
            for (int b = 0; b < WIDTH; b++) mb[s*E+b] = m_d[s][b];
            mb[s*E+WIDTH] = m_v[s];
            if (PAR == 1) mb[s*E+E-1] = m_p[s];
        end
    endfunction

    function automatic void unpack_m();
        for (int s = 0; s < DEPTH; s++) begin
            for (int b = 0; b < WIDTH; b++) m_d[s][b] = mb[s*E+b];
            m_v[s] = mb[s*E+WIDTH];
            if (PAR == 1) m_p[s] = mb[s*E+E-1];
        end
    endfunction

    function automatic void model_edge(bit se, bit en, logic [WIDTH-1:0] d, bit dv, bit si);
        int old = m_scnt;
        if (se) begin
            pack_m();
            for (int i = L - 1; i > 0; i--) mb[i] = mb[i-1];
            mb[0] = si;
            unpack_m();
            m_scnt  = (old < L) ? old + 1 : L;
            m_sdone = (old == L - 1);
        end else begin
            if (PAR == 1 && m_v[DEPTH-1] && ((^m_d[DEPTH-1]) != m_p[DEPTH-1])) m_perr = 1;
            if (en) begin
                for (int s = DEPTH - 1; s > 0; s--) begin
                    m_d[s] = m_d[s-1]; m_v[s] = m_v[s-1]; m_p[s] = m_p[s-1];
                end
                m_d[0] = d; m_v[0] = dv; m_p[0] = ^d;
            end
            m_scnt = 0; m_sdone = 0;
        end
    endfunction

    function automatic bit m_so();
        pack_m();
        return mb[L-1];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".Q"},     32'(bus.Q),     32'(m_d[DEPTH-1]));
        chk({tag, ".QV"},    32'(bus.QV),    32'(m_v[DEPTH-1]));
        chk({tag, ".SO"},    32'(bus.SO),    32'(m_so()));
        chk({tag, ".SCNT"},  32'(bus.SCNT),  32'(m_scnt));
        chk({tag, ".SDONE"}, 32'(bus.SDONE), 32'(m_sdone));
        chk({tag, ".PERR"},  32'(bus.PERR),  32'(m_perr));
    endtask

    // One clock edge: model sees the same inputs the DUT samples, compare 1 time unit later.
    task automatic step(input string tag);
        @(posedge CP);
        model_edge(bus.SE, bus.EN, bus.D, bus.DV, bus.SI);
        #1;
        check_all(tag);
    endtask

    task automatic pulse_cd(input string tag);
        #2 CD = 1'b1;
        m_reset();
        #1 check_all(tag);
        #1 CD = 1'b0;
    endtask

    bit so_seq [9];

    initial begin
        bus.SE = 0; bus.SI = 0; bus.EN = 0; bus.D = '0; bus.DV = 0;
        m_reset();
        #3 check_all("reset");
        @(posedge CP); #1 CD = 1'b0;

        // Functional pipeline and hold
        bus.EN = 1; bus.D = 8'hA5; bus.DV = 1; step("fn1");
        bus.D = 8'h3C; bus.DV = 0;             step("fn2");
        chk("fn2_q", 32'(bus.Q), 32'hA5);  chk("fn2_qv", 32'(bus.QV), 32'd1);
        bus.D = 8'h11; bus.DV = 1;             step("fn3");
        chk("fn3_q", 32'(bus.Q), 32'h3C);  chk("fn3_qv", 32'(bus.QV), 32'd0);
        bus.EN = 0; bus.D = 8'hFF;
        for (int i = 0; i < 4; i++) step("hold");
        chk("hold_q", 32'(bus.Q), 32'h3C); chk("hold_qv", 32'(bus.QV), 32'd0);

        // Asynchronous clear between edges
        pulse_cd("cd_mid");

        // Preload A5/valid, then full scan with SI=1
        bus.EN = 1; bus.D = 8'hA5; bus.DV = 1; step("pre1"); step("pre2");
        bus.EN = 0; bus.SE = 1; bus.SI = 1;
        so_seq = '{1, 1, 0, 1, 0, 0, 1, 0, 1};
`ifndef SCAN_PIPE_PARITY_EN
        chk("so0", 32'(bus.SO), 32'(so_seq[0]));
`endif
        for (int i = 1; i <= L; i++) begin
            step("shift");
`ifndef SCAN_PIPE_PARITY_EN
            if (i < 9) chk($sformatf("so%0d", i), 32'(bus.SO), 32'(so_seq[i]));
`endif
            if (i == L - 1) chk("sdone_early", 32'(bus.SDONE), 32'd0);
        end
        chk("scnt_full", 32'(bus.SCNT), 32'(L));
        chk("sdone_full", 32'(bus.SDONE), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step("sat");
            chk("sat_scnt", 32'(bus.SCNT), 32'(L));
            chk("sat_sdone", 32'(bus.SDONE), 32'd0);
        end
        bus.SE = 0; step("se_drop");
        chk("ld_q", 32'(bus.Q), 32'hFF); chk("ld_qv", 32'(bus.QV), 32'd1);
        chk("se_drop_scnt", 32'(bus.SCNT), 32'd0);
        bus.SE = 1; step("se_rise");
        chk("se_rise_scnt", 32'(bus.SCNT), 32'd1);

        // Clear after shift 7, then a fresh full count
        bus.SI = 0;
        for (int i = 2; i <= 7; i++) step("pre_cd");
        pulse_cd("cd_shift");
        for (int i = 1; i <= L; i++) begin
            bus.SI = 1'($urandom_range(0, 1));
            step("resume");
            if (i == L - 1) chk("resume_sdone_lo", 32'(bus.SDONE), 32'd0);
        end
        chk("resume_sdone", 32'(bus.SDONE), 32'd1);

        // Scan-load stage DEPTH-1 with Q=0x01, QV=1, parity=0
        for (int i = 0; i < L; i++) tgt[i] = 0;
        tgt[(DEPTH-1)*E] = 1;
        tgt[(DEPTH-1)*E+WIDTH] = 1;
        for (int p = L - 1; p >= 0; p--) begin
            bus.SI = tgt[p];
            step("pload");
        end
        chk("pload_q", 32'(bus.Q), 32'h01); chk("pload_qv", 32'(bus.QV), 32'd1);
        bus.SE = 0; bus.EN = 0;
        step("perr_edge");
        chk("perr_set", 32'(bus.PERR), 32'(PAR));
        for (int i = 0; i < 3; i++) step("perr_hold");
        chk("perr_sticky", 32'(bus.PERR), 32'(PAR));
        pulse_cd("perr_clr");

        // Randomized mix: long-ish scan runs, random data, occasional clears
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) bus.SE = ~bus.SE;
            bus.EN = 1'($urandom_range(0, 1));
            bus.D  = 8'($urandom());
            bus.DV = 1'($urandom_range(0, 1));
            bus.SI = 1'($urandom_range(0, 1));
            step("rand");
            if ($urandom_range(0, 63) == 0) pulse_cd("rand_cd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
